elevator_scheduler: RTL and testbench

Request scheduler and car sequencer for the elevator. It latches the one-cycle `key_press` pulses from `key_input` into a pending-floor register and runs a collective (SCAN) policy: it keeps the current direction while requests lie ahead and reverses otherwise. It steps the car floor by floor with a per-floor travel timer and opens the door for a fixed dwell at each requested floor. Its outputs drive the floor display and the motor and door indicators.

---
 rtl/elevator_pkg.sv | 21 ++
 rtl/dwell_timer.sv | 22 ++
 rtl/elevator_scheduler.sv | 134 +++++++++++++
 tb/tb_elevator_scheduler.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared elevator types: FSM state encoding, default timing, floor index width helper.
package elevator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_DOOR = 2'd2
  } state_t;

  localparam int DEF_W           = 4;
  localparam int DEF_MOVE_CYCLES = 4;
  localparam int DEF_DOOR_CYCLES = 6;

  // Width of a floor index; never below one bit so a single-floor build still has a port.
  function automatic int floor_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [floor_w(DEF_W)-1:0] floor_t;

endpackage

// File: rtl/dwell_timer.sv
// Shared travel/door timer: counts 0..limit_i while enabled, wraps to 0 after terminal count.
module dwell_timer #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [CW-1:0] limit_i,
  output logic          tc_o
);

  logic [CW-1:0] cnt_q;

  assign tc_o = (cnt_q == limit_i);

  always_ff @(posedge clk) begin
    if (rst || clr_i) cnt_q <= '0;
    else if (en_i)    cnt_q <= tc_o ? '0 : cnt_q + CW'(1);
  end

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN elevator scheduler: request latch, IDLE/MOVE/DOOR sequencer, floor stepping.
// Optional ELEVATOR_DOOR_REOPEN_EN: a current-floor press during DOOR restarts the dwell.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int W           = DEF_W,
  parameter int MOVE_CYCLES = DEF_MOVE_CYCLES,
  parameter int DOOR_CYCLES = DEF_DOOR_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [W-1:0]          key_press,
  output logic [floor_w(W)-1:0] cur_floor,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic [W-1:0]          pending
);

  localparam int FW   = floor_w(W);
  localparam int TMAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int CW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  state_t        state_q, state_d;
  logic [FW-1:0] floor_q, floor_d, nxt_floor;
  logic          dir_q, dir_d;
  logic [W-1:0]  pend_q, pend_d, srv_clr, key_eff;
  logic          moving_q, door_q;
  logic          above, below, ahead, opposite, beyond_nxt;
  logic          door_hit, tmr_clr, tmr_tc;
  logic [CW-1:0] tmr_lim;

  assign nxt_floor = dir_q ? floor_q + FW'(1) : floor_q - FW'(1);
  assign ahead     = dir_q ? above : below;
  assign opposite  = dir_q ? below : above;
  assign door_hit  = (state_q == ST_DOOR) && key_press[floor_q];
  assign tmr_lim   = (state_q == ST_MOVE) ? CW'(MOVE_CYCLES - 1) : CW'(DOOR_CYCLES - 1);

  always_comb begin
    above      = 1'b0;
    below      = 1'b0;
    beyond_nxt = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i > int'(floor_q)) above = above | pend_q[i];
      if (i < int'(floor_q)) below = below | pend_q[i];
      // Requests past the floor being entered, in the travel direction.
      if (dir_q  && i > int'(nxt_floor)) beyond_nxt = beyond_nxt | pend_q[i];
      if (!dir_q && i < int'(nxt_floor)) beyond_nxt = beyond_nxt | pend_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    floor_d = floor_q;
    dir_d   = dir_q;
    srv_clr = '0;
    tmr_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tmr_clr = 1'b1;
        if (pend_q[floor_q]) begin
          state_d          = ST_DOOR;
          srv_clr[floor_q] = 1'b1;
        end else if (ahead) begin
          state_d = ST_MOVE;
        end else if (opposite) begin
          state_d = ST_MOVE;
          dir_d   = ~dir_q;
        end
      end
      ST_MOVE: begin
        if (tmr_tc) begin
          floor_d = nxt_floor;
          if (pend_q[nxt_floor]) begin
            state_d            = ST_DOOR;
            srv_clr[nxt_floor] = 1'b1;
          end else if (!beyond_nxt) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DOOR: begin
`ifdef ELEVATOR_DOOR_REOPEN_EN
        if (door_hit)    tmr_clr = 1'b1;
        else if (tmr_tc) state_d = ST_IDLE;
`else
        if (tmr_tc) state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A press of the floor whose door is open is never latched.
  always_comb begin
    key_eff = key_press;
    if (door_hit) key_eff[floor_q] = 1'b0;
    pend_d = (pend_q | key_eff) & ~srv_clr;
  end

  dwell_timer #(.CW(CW)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (tmr_clr),
    .en_i    (state_q != ST_IDLE),
    .limit_i (tmr_lim),
    .tc_o    (tmr_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      floor_q  <= '0;
      dir_q    <= 1'b1;
      pend_q   <= '0;
      moving_q <= 1'b0;
      door_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      floor_q  <= floor_d;
      dir_q    <= dir_d;
      pend_q   <= pend_d;
      moving_q <= (state_d == ST_MOVE);
      door_q   <= (state_d == ST_DOOR);
    end
  end

  assign cur_floor = floor_q;
  assign dir_up    = dir_q;
  assign moving    = moving_q;
  assign door_open = door_q;
  assign pending   = pend_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Scoreboard bench: expected stops (floor, direction, door length) queued with stimulus, checked on door opening.
module tb_elevator_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_press;
  logic [1:0] cur_floor;
  logic       dir_up, moving, door_open;
  logic [3:0] pending;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    int floor;
    int dir;
    int len;
  } stop_t;

  stop_t exp_q[$];
  stop_t cur_stop;
  bit    in_door = 1'b0;
  int    door_len = 0;

`ifdef ELEVATOR_DOOR_REOPEN_EN
  localparam int REOPEN_LEN = 10;
`else
  localparam int REOPEN_LEN = 6;
`endif

  elevator_scheduler #(.W(4), .MOVE_CYCLES(4), .DOOR_CYCLES(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_press (key_press),
    .cur_floor (cur_floor),
    .dir_up    (dir_up),
    .moving    (moving),
    .door_open (door_open),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Door monitor: pops one expected stop per door opening and checks the dwell length on close.
  always @(negedge clk) begin
    if (rst) begin
      in_door = 1'b0;
    end else if (door_open && !in_door) begin
      in_door  = 1'b1;
      door_len = 1;
      chk("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        cur_stop = exp_q.pop_front();
        chk("stop_floor", cur_floor, cur_stop.floor);
        chk("stop_dir", dir_up, cur_stop.dir);
      end
    end else if (door_open) begin
      door_len++;
    end else if (in_door) begin
      in_door = 1'b0;
      chk("door_len", door_len, cur_stop.len);
    end
  end

  task automatic push_stop(input int f, input int d, input int len);
    stop_t s;
    s.floor = f; s.dir = d; s.len = len;
    exp_q.push_back(s);
  endtask

  // Returns at the negedge right after the press was latched.
  task automatic press(input logic [3:0] v);
    @(negedge clk);
    key_press = v;
    @(negedge clk);
    key_press = '0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((moving || door_open || pending != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", n < 500, 1);
    @(negedge clk);
  endtask

  task automatic wait_floor(input int f);
    int n = 0;
    while (int'(cur_floor) != f && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("floor_wait", n < 200, 1);
  endtask

  task automatic wait_door();
    int n = 0;
    while (!door_open && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("door_wait", n < 200, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    rst       = 1'b1;
    key_press = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_floor", cur_floor, 0);
    chk("rst_dir", dir_up, 1);
    chk("rst_moving", moving, 0);
    chk("rst_door", door_open, 0);
    chk("rst_pending", pending, 0);

    // Same-floor call.
    push_stop(0, 1, 6);
    press(4'b0001);
    chk("same_pend_latched", pending, 4'b0001);
    chk("same_door_early", door_open, 0);
    @(negedge clk);
    chk("same_door_open", door_open, 1);
    chk("same_pend_cleared", pending, 0);
    wait_idle();

    // Travel up 0 -> 3.
    push_stop(3, 1, 6);
    press(4'b1000);
    chk("up_not_moving_yet", moving, 0);
    cnt = 0;
    @(negedge clk);
    while (moving && cnt < 100) begin
      cnt++;
      if (cnt == 5) chk("up_floor1", cur_floor, 1);
      if (cnt == 9) chk("up_floor2", cur_floor, 2);
      @(negedge clk);
    end
    chk("up_move_len", cnt, 12);
    chk("up_arrive", cur_floor, 3);
    chk("up_door", door_open, 1);
    wait_idle();

    // Return to 0, then collective service upward with a late call behind.
    push_stop(0, 0, 6);
    press(4'b0001);
    wait_idle();
    push_stop(2, 1, 6);
    push_stop(3, 1, 6);
    push_stop(1, 0, 6);
    press(4'b1000);
    wait_floor(1);
    press(4'b0100);
    wait_floor(2);
    press(4'b0010);
    chk("coll_pend_mid", pending, 4'b1010);
    wait_idle();
    chk("coll_end_floor", cur_floor, 1);
    chk("coll_end_dir", dir_up, 0);

    // Simultaneous presses from floor 3.
    push_stop(3, 1, 6);
    press(4'b1000);
    wait_idle();
    push_stop(2, 0, 6);
    push_stop(0, 0, 6);
    press(4'b0101);
    chk("sim_pend0", pending, 4'b0101);
    wait_door();
    chk("sim_pend1", pending, 4'b0001);
    wait_idle();
    chk("sim_pend2", pending, 0);
    chk("sim_floor", cur_floor, 0);

    // Reset between floors 1 and 2.
    press(4'b1000);
    wait_floor(1);
    @(negedge clk);
    chk("mid_moving", moving, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_floor", cur_floor, 0);
    chk("mrst_moving", moving, 0);
    chk("mrst_pending", pending, 0);
    chk("mrst_dir", dir_up, 1);
    chk("mrst_door", door_open, 0);
    repeat (3) @(negedge clk);
    chk("mrst_stays_idle", moving, 0);

    // Current-floor press in door cycle 4, together with another floor.
    push_stop(0, 1, REOPEN_LEN);
    push_stop(1, 1, 6);
    press(4'b0001);
    @(negedge clk);
    chk("dr_open", door_open, 1);
    repeat (3) @(negedge clk);
    key_press = 4'b0011;
    @(negedge clk);
    key_press = '0;
    chk("dr_pend", pending, 4'b0010);
    chk("dr_still_open", door_open, 1);
    wait_idle();
    chk("dr_end_floor", cur_floor, 1);

    repeat (2) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
